// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and types for the mux_scan_n block.
//   MODE_MANUAL / MODE_SCAN : values of the mux_scan_n.mode input
//   state_e                 : operating state (IDLE / MANUAL / SCAN)
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_n_scan_counter.sv
// scan_counter: dwell counter and channel pointer for the scan mode of mux_scan_n.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the dwell counter / pointer this cycle
//   clear      : force pointer and counter back to 0 (has priority over run)
//   ptr        : current scan channel
//   wrap_next  : pointer has just wrapped N-1 -> 0 and that channel 0 has not
//                yet been sampled; the next scan sample is the first of a sweep
module scan_counter
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DWELL = 4,
  parameter int unsigned SW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          clear,
  output logic [SW-1:0] ptr,
  output logic          wrap_next
);

  localparam int unsigned   CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          wrap_q, wrap_d;

  // The wrap flag survives an idle pause so the pulse is still emitted
  // alongside the first channel-0 sample once scanning resumes.
  always_comb begin
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    wrap_d = wrap_q;
    if (clear) begin
      cnt_d  = '0;
      ptr_d  = '0;
      wrap_d = 1'b0;
    end else if (run) begin
      wrap_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (ptr_q == PTR_LAST) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr       = ptr_q;
  assign wrap_next = wrap_q;

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel, W-bit registered multiplexer with manual and scan modes.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : N channels, channel k at [k*W +: W]
//   en         : block enable (0 = idle, internal state frozen)
//   mode       : 0 = manual (sel_in), 1 = scan (internal pointer, DWELL cycles each)
//   sel_in     : manual channel select
//   out_data   : registered selected channel data
//   out_sel    : channel index belonging to out_data
//   out_valid  : out_data is a freshly sampled legal channel
//   sel_err    : last manual select was >= N
//   wrap       : one-cycle pulse with the first channel-0 sample of a new sweep
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned SW    = $clog2(N),
  parameter int unsigned DWELL = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel_in,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  output logic           sel_err,
  output logic           wrap
);

  localparam logic [SW:0] N_LIM = (SW + 1)'(N);

  state_e        state_q, state_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          sel_err_q, sel_err_d;
  logic          wrap_q, wrap_d;

  logic [SW-1:0] ptr;
  logic          wrap_next;
  logic [SW-1:0] idx;
  logic [W-1:0]  pick;
  logic          sel_legal;

  always_comb begin
    if (!en) begin
      state_d = ST_IDLE;
    end else if (mode == MODE_SCAN) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_MANUAL;
    end
  end

  scan_counter #(
    .N     (N),
    .DWELL (DWELL),
    .SW    (SW)
  ) u_scan_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_d == ST_SCAN),
    .clear     (state_d == ST_MANUAL),
    .ptr       (ptr),
    .wrap_next (wrap_next)
  );

  assign sel_legal = {1'b0, sel_in} < N_LIM;
  assign idx       = (state_d == ST_SCAN) ? ptr : sel_in;

  // Out-of-range indices match no channel and yield zero.
  always_comb begin
    pick = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SW'(k)) begin
        pick = in_data[k*W +: W];
      end
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    sel_err_d  = 1'b0;
    wrap_d     = 1'b0;
    unique case (state_d)
      ST_MANUAL: begin
        if (sel_legal) begin
          out_data_d = pick;
          out_sel_d  = sel_in;
        end else begin
          out_data_d = '0;
          sel_err_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        out_data_d = pick;
        out_sel_d  = ptr;
        wrap_d     = wrap_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_data_q <= '0;
      out_sel_q  <= '0;
      sel_err_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      sel_err_q  <= sel_err_d;
      wrap_q     <= wrap_d;
    end
  end

  // Validity is decoded from registered state rather than kept in its own flop.
  assign out_valid = (state_q == ST_SCAN) || ((state_q == ST_MANUAL) && !sel_err_q);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign sel_err   = sel_err_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
Parametrised N-channel, W-bit registered multiplexer, the next generation of the team's 8:1 single-bit muxes.
- Two modes:
  - Manual: the select comes from a port.
  - Scan: an internal pointer steps through every channel, holding each one for DWELL cycles.
- Sits between grouped source buses and a single downstream consumer (display/probe/serial stage).
- Output is registered with a valid flag and a wrap strobe.

Parameters:
- N, 8, number of input channels (≥2).
- W, 1, data width per channel (≥1).
- SW, $clog2(N), select width (derived; not overridden).
- DWELL, 4, cycles each channel is held in scan mode (≥1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- en  in  1  block enable; 0 freezes internal state.
- mode  in  1  0 = manual, 1 = scan.
- sel_in  in  SW  channel select in manual mode.
- out_data  out  W  registered selected data.
- out_sel  out  SW  channel index corresponding to out_data.
- out_valid  out  1  out_data is a legal, freshly sampled channel.
- sel_err  out  1  manual sel_in ≥ N this cycle (registered).
- wrap  out  1  one-cycle pulse when the scan pointer returns N-1 → 0.

Behaviour:
- Reset (rst_n = 0, asynchronous; effective immediately, also mid-scan):
  - out_data = 0, out_sel = 0, out_valid = 0, sel_err = 0, wrap = 0.
  - Scan pointer = 0, dwell counter = 0, state = IDLE.
- State machine, evaluated each rising edge:
  - IDLE: entered when en = 0.
  - MANUAL: entered when en = 1 and mode = 0.
  - SCAN: entered when en = 1 and mode = 1.
- IDLE:
  - Pointer, counter, out_data and out_sel hold.
  - out_valid = 0, wrap = 0, sel_err = 0.
- MANUAL (latency 1 cycle, sel_in/in_data sampled at edge t, visible after t):
  - sel_in < N: out_data ← in_data[sel_in], out_sel ← sel_in, out_valid ← 1, sel_err ← 0.
  - sel_in ≥ N (only possible when N is not a power of 2): out_data ← 0, out_sel holds, out_valid ← 0, sel_err ← 1.
  - Scan pointer and dwell counter are cleared to 0 while in MANUAL.
- SCAN:
  - Every cycle: out_data ← in_data[ptr], out_sel ← ptr, out_valid ← 1, sel_err ← 0. Data is re-sampled each cycle, not latched once per dwell.
  - Dwell counter runs 0..DWELL-1.
  - At DWELL-1: counter ← 0; ptr ← ptr+1, or ptr ← 0 if ptr = N-1.
  - wrap ← 1 on the cycle after ptr transitions N-1 → 0, i.e. aligned with the first out_sel = 0 of the new sweep. Otherwise 0.
  - DWELL = 1: ptr advances every cycle.
  - Full sweep length = N·DWELL cycles.
- Mode transitions:
  - MANUAL → SCAN: sweep starts at ptr 0 with counter 0, so the first scan output is channel 0, held DWELL cycles.
  - SCAN → MANUAL: takes effect at the same edge (sel_in sampled). No wrap pulse is generated.
  - SCAN → IDLE → SCAN: resumes from the held ptr/counter, so an en pause does not restart the sweep.
- en and mode changing simultaneously: en has priority (en = 0 → IDLE regardless of mode).
- No combinational path from any input to any output.

Decomposition:
- Package mux_scan_pkg:
  - Mode constants MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1.
  - State encoding IDLE/MANUAL/SCAN (2-bit localparam).
  - Function clog2 helper if the tool flow needs it.
- Sub-module scan_counter (parameters N, DWELL):
  - Inputs: clk, rst_n, run, clear.
  - Outputs: ptr[SW], wrap_next.
  - Contains the dwell counter and pointer.
- Top level holds the FSM, N-to-1 selection and output registers.

Test Plan:
1. Reset mid-scan: N=8, W=4, DWELL=2, scanning ptr=5; assert rst_n=0 between edges → outputs 0 immediately. Release → stays IDLE with en=0.
2. Manual sweep: N=8, W=1, in_data=8'b1010_0110, mode=0, en=1, sel_in 0..7 one per cycle → out_data 0,1,1,0,0,1,0,1 one cycle later. out_valid=1, out_sel tracks sel_in delayed 1.
3. Scan with dwell: N=4, W=8, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, DWELL=3, mode=1 → out_data A0×3, B1×3, C2×3, D3×3, A0…. wrap=1 exactly on the first A0 of each later sweep (every 12 cycles).
4. Illegal select: N=6, manual sel_in=7 → next cycle sel_err=1, out_valid=0, out_data=0, out_sel unchanged. sel_in=2 → sel_err=0, out_sel=2.
5. Pause/resume: scan N=8, DWELL=4, drop en for 5 cycles at ptr=3, counter=1 → outputs hold, out_valid=0. Restore en → ptr=3 for 2 more cycles, then ptr=4.
6. Cross-check against the existing 8:1 muxes: N=8, W=1, manual mode, DataSource incrementing every cycle and Select every 256 cycles → out_data equals the existing mux output delayed by 1 cycle, with no mismatch over all 2048 combinations.
